sirv_debug_haltctrl: RTL and testbench
======================================

# sirv_debug_haltctrl

Debug-module-side halt/resume controller, the initiator end of the core's debug CSR interface. It turns debugger halt and resume commands into the debug interrupt and resume/step flags the core consumes. It tracks the core's debug-mode status to report halted or running and to pulse acknowledges. A bounded timeout covers a core that never responds. It sits between the DM register file and the core's debug CSR block, on the core clock.

## Interface
Parameters:
- CNT_W, 10: width of the handshake timeout counter.
- TO_CYC, 1023: terminal count for the timeout; must be below 2^CNT_W.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- halt_req_i  in  1  one-cycle halt command from the DM.
- resume_req_i  in  1  one-cycle resume command from the DM.
- step_i  in  1  sampled with resume_req_i; 1 = resume as a single step.
- core_dbg_mode  in  1  core is in debug mode (nonzero dcause); same clock domain, no synchronizer.
- core_dcause  in  3  core debug cause field.
- dbg_irq_o  out  1  debug interrupt to the core; level.
- resume_flag_o  out  1  resume request polled by the debug ROM; level.
- step_flag_o  out  1  step request for the pending resume; level.
- halted_o  out  1  controller is in HALTED.
- busy_o  out  1  controller is in HALTREQ or RESUMING.
- halt_ack_o  out  1  one-cycle pulse on entry to HALTED.
- resume_ack_o  out  1  one-cycle pulse on the HALTED/RESUMING-to-RUNNING exit.
- timeout_o  out  1  one-cycle pulse when a handshake is abandoned.
- halt_cause_o  out  3  core_dcause latched on entry to HALTED.

## Operation
- All outputs are registered.
- Reset value of every output is 0, and the state is RUNNING.
- States: RUNNING, HALTREQ, HALTED, RESUMING.
- RUNNING:
  - core_dbg_mode=1 -> HALTED. This is the unsolicited entry (ebreak or step completion) and takes priority over halt_req_i.
  - Else halt_req_i=1 -> HALTREQ.
  - resume_req_i is ignored.
- HALTREQ:
  - dbg_irq_o=1 for the whole state.
  - core_dbg_mode=1 -> HALTED.
  - Else timeout -> RUNNING with timeout_o pulse.
  - halt_req_i and resume_req_i are ignored.
- HALTED:
  - resume_req_i=1 -> RESUMING; step_flag_o is loaded from step_i.
  - core_dbg_mode=0 (core left on its own) -> RUNNING with resume_ack_o pulse. This takes priority over resume_req_i.
  - halt_req_i is ignored.
- RESUMING:
  - resume_flag_o=1 for the whole state.
  - core_dbg_mode=0 -> RUNNING with resume_ack_o pulse.
  - Else timeout -> HALTED with timeout_o pulse; no halt_ack_o pulse.
- Every entry to HALTED pulses halt_ack_o and loads halt_cause_o from core_dcause. A timeout return from RESUMING is the only exception: it pulses neither and leaves halt_cause_o unchanged.
- step_flag_o:
  - Holds through RESUMING and RUNNING.
  - Clears on the next entry to HALTED, so a step completion re-enters through RUNNING -> HALTED.
  - Also clears on the RESUMING timeout.
- Timeout counter:
  - Cleared to 0 on entry to HALTREQ or RESUMING.
  - Increments by 1 each cycle spent in that state without an exit.
  - Timeout fires when the counter equals TO_CYC and no exit condition is true. The state therefore lasts at most TO_CYC+1 cycles.
  - The counter does not wrap; it is held at 0 outside HALTREQ and RESUMING.
- An exit condition and a timeout in the same cycle: the exit wins and timeout_o stays 0.
- Reset asserted mid-handshake: immediate return to RUNNING with all outputs 0. A core still in debug mode after reset is then captured as an unsolicited HALTED entry.

## Timing
- halt_req_i high before edge N -> dbg_irq_o=1 and busy_o=1 after edge N.
- core_dbg_mode rising before edge M:
  - After edge M: halted_o=1, halt_ack_o=1 for one cycle, dbg_irq_o=0.
  - halt_cause_o is valid from edge M.
- resume_req_i before edge N -> resume_flag_o=1 after edge N.
- core_dbg_mode falling before edge M -> after edge M: resume_flag_o=0, halted_o=0, resume_ack_o=1 for one cycle.
- Minimum halt round trip: 2 cycles from command to halt_ack_o, assuming the core raises core_dbg_mode one cycle after dbg_irq_o.
- Command pulses arriving in a state that ignores them are dropped, not queued.

## Test plan
- TO_CYC=15. Pulse halt_req_i; core raises core_dbg_mode 3 cycles later with core_dcause=3 -> dbg_irq_o high for exactly 3 cycles, then halt_ack_o one pulse, halted_o=1, halt_cause_o=3.
- From HALTED, resume_req_i with step_i=0. core_dbg_mode drops 2 cycles later -> resume_flag_o high for 2 cycles, resume_ack_o one pulse, halted_o=0, step_flag_o=0.
- Step: resume_req_i with step_i=1. Core drops debug mode, then re-raises it 4 cycles later with dcause=4 -> step_flag_o=1 until the re-entry edge, then halt_ack_o pulses, halt_cause_o=4, step_flag_o=0.
- Halt timeout: halt_req_i with core_dbg_mode stuck at 0 -> dbg_irq_o high for 16 cycles, timeout_o one pulse, state RUNNING, halt_ack_o never pulses.
- Resume timeout: core_dbg_mode stuck at 1 -> resume_flag_o high for 16 cycles, timeout_o pulse, halted_o=1, halt_ack_o not pulsed. Then core_dbg_mode rises on the exact timeout cycle of a new halt -> halt_ack_o pulses, timeout_o=0.
- Reset: assert rst_n=0 mid-HALTREQ -> all outputs 0 immediately. Release with core_dbg_mode=1 -> HALTED with halt_ack_o pulse one edge after release.

Source files
------------

// File: rtl/sirv_debug_haltctrl.sv
// sirv_debug_haltctrl
// Debug-module-side halt/resume controller. It turns one-cycle halt and
// resume commands from the DM into the level signals the core's debug CSR
// block consumes: debug interrupt, resume flag and step flag. It follows
// the core's debug-mode status to report halted/running, pulses
// acknowledges, and abandons a handshake the core never answers.
//
// Handshake semantics: halt_req_i and resume_req_i are single-cycle command
// strobes. They are acted on only in the state that accepts them (halt in
// RUNNING, resume in HALTED). Anywhere else they are dropped, not queued.
// core_dbg_mode is the core's level answer and is always sampled, so an
// unsolicited entry to debug mode (ebreak, step completion) or an
// unsolicited exit is followed from any state.

module sirv_debug_haltctrl #(
   parameter int CNT_W  = 10,
   parameter int TO_CYC = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       halt_req_i,
   input  logic       resume_req_i,
   input  logic       step_i,
   input  logic       core_dbg_mode,
   input  logic [2:0] core_dcause,
   output logic       dbg_irq_o,
   output logic       resume_flag_o,
   output logic       step_flag_o,
   output logic       halted_o,
   output logic       busy_o,
   output logic       halt_ack_o,
   output logic       resume_ack_o,
   output logic       timeout_o,
   output logic [2:0] halt_cause_o
);

   // Terminal count and increment, sized to the counter.
   localparam logic [CNT_W-1:0] LP_TO_CNT = CNT_W'(TO_CYC);
   localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] LP_ZERO   = '0;

   typedef enum logic [1:0] {
      ST_RUNNING  = 2'd0,
      ST_HALTREQ  = 2'd1,
      ST_HALTED   = 2'd2,
      ST_RESUMING = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dbg_irq;
   logic             r_resume_flag;
   logic             r_step_flag;
   logic             r_halted;
   logic             r_busy;
   logic             r_halt_ack;
   logic             r_resume_ack;
   logic             r_timeout;
   logic [2:0]       r_halt_cause;

   // Handshake decode. The exit conditions are checked before the timeout
   // so that an answer arriving on the terminal cycle still wins.
   logic w_core_in;
   logic w_core_out;
   logic w_cnt_done;

   assign w_core_in  = core_dbg_mode;
   assign w_core_out = ~core_dbg_mode;
   assign w_cnt_done = (r_cnt == LP_TO_CNT);

   // Single state machine; every output is a register updated with the
   // state transition that defines it, so outputs change exactly at the edge
   // where the state changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RUNNING;
         r_cnt         <= LP_ZERO;
         r_dbg_irq     <= 1'b0;
         r_resume_flag <= 1'b0;
         r_step_flag   <= 1'b0;
         r_halted      <= 1'b0;
         r_busy        <= 1'b0;
         r_halt_ack    <= 1'b0;
         r_resume_ack  <= 1'b0;
         r_timeout     <= 1'b0;
         r_halt_cause  <= 3'd0;
      end else begin
         // Pulse outputs default low; only the transition that owns them
         // raises them for one cycle.
         r_halt_ack   <= 1'b0;
         r_resume_ack <= 1'b0;
         r_timeout    <= 1'b0;

         case (r_state)
            ST_RUNNING: begin
               // Unsolicited entry beats a pending halt command.
               if (w_core_in) begin
                  r_state      <= ST_HALTED;
                  r_halted     <= 1'b1;
                  r_halt_ack   <= 1'b1;
                  r_halt_cause <= core_dcause;
                  r_step_flag  <= 1'b0;
                  r_cnt        <= LP_ZERO;
               end else if (halt_req_i) begin
                  r_state   <= ST_HALTREQ;
                  r_dbg_irq <= 1'b1;
                  r_busy    <= 1'b1;
                  r_cnt     <= LP_ZERO;
               end
            end

            ST_HALTREQ: begin
               if (w_core_in) begin
                  r_state      <= ST_HALTED;
                  r_dbg_irq    <= 1'b0;
                  r_busy       <= 1'b0;
                  r_halted     <= 1'b1;
                  r_halt_ack   <= 1'b1;
                  r_halt_cause <= core_dcause;
                  r_step_flag  <= 1'b0;
                  r_cnt        <= LP_ZERO;
               end else if (w_cnt_done) begin
                  // Core never took the interrupt: give up and drop it.
                  r_state   <= ST_RUNNING;
                  r_dbg_irq <= 1'b0;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
                  r_cnt     <= LP_ZERO;
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end

            ST_HALTED: begin
               // Core leaving on its own beats a resume command.
               if (w_core_out) begin
                  r_state      <= ST_RUNNING;
                  r_halted     <= 1'b0;
                  r_resume_ack <= 1'b1;
               end else if (resume_req_i) begin
                  r_state       <= ST_RESUMING;
                  r_halted      <= 1'b0;
                  r_busy        <= 1'b1;
                  r_resume_flag <= 1'b1;
                  r_step_flag   <= step_i;
                  r_cnt         <= LP_ZERO;
               end
            end

            ST_RESUMING: begin
               if (w_core_out) begin
                  // step_flag_o is kept so a single step can complete and
                  // come back through RUNNING -> HALTED.
                  r_state       <= ST_RUNNING;
                  r_resume_flag <= 1'b0;
                  r_busy        <= 1'b0;
                  r_resume_ack  <= 1'b1;
                  r_cnt         <= LP_ZERO;
               end else if (w_cnt_done) begin
                  // Core stayed in debug mode: fall back to HALTED without
                  // treating it as a new halt (no ack, cause untouched).
                  r_state       <= ST_HALTED;
                  r_resume_flag <= 1'b0;
                  r_step_flag   <= 1'b0;
                  r_busy        <= 1'b0;
                  r_halted      <= 1'b1;
                  r_timeout     <= 1'b1;
                  r_cnt         <= LP_ZERO;
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end

            default: begin
               r_state       <= ST_RUNNING;
               r_cnt         <= LP_ZERO;
               r_dbg_irq     <= 1'b0;
               r_resume_flag <= 1'b0;
               r_step_flag   <= 1'b0;
               r_halted      <= 1'b0;
               r_busy        <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_irq_o     = r_dbg_irq;
   assign resume_flag_o = r_resume_flag;
   assign step_flag_o   = r_step_flag;
   assign halted_o      = r_halted;
   assign busy_o        = r_busy;
   assign halt_ack_o    = r_halt_ack;
   assign resume_ack_o  = r_resume_ack;
   assign timeout_o     = r_timeout;
   assign halt_cause_o  = r_halt_cause;

endmodule

// File: tb/tb_sirv_debug_haltctrl.sv
// tb_sirv_debug_haltctrl
// Directed scenarios from the halt/resume protocol plus a randomized run
// checked every cycle against a mode-level reference model.

module tb_sirv_debug_haltctrl;

   localparam int TO = 15;

   logic       clk;
   logic       rst_n;
   logic       halt_req_i;
   logic       resume_req_i;
   logic       step_i;
   logic       core_dbg_mode;
   logic [2:0] core_dcause;
   logic       dbg_irq_o;
   logic       resume_flag_o;
   logic       step_flag_o;
   logic       halted_o;
   logic       busy_o;
   logic       halt_ack_o;
   logic       resume_ack_o;
   logic       timeout_o;
   logic [2:0] halt_cause_o;

   int n_tests = 0;
   int n_fail  = 0;

   sirv_debug_haltctrl #(.CNT_W(5), .TO_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .halt_req_i(halt_req_i), .resume_req_i(resume_req_i), .step_i(step_i),
      .core_dbg_mode(core_dbg_mode), .core_dcause(core_dcause),
      .dbg_irq_o(dbg_irq_o), .resume_flag_o(resume_flag_o),
      .step_flag_o(step_flag_o), .halted_o(halted_o), .busy_o(busy_o),
      .halt_ack_o(halt_ack_o), .resume_ack_o(resume_ack_o),
      .timeout_o(timeout_o), .halt_cause_o(halt_cause_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Tracks the controller's mode by name and how many cycles the current
   // handshake has been waiting; outputs are derived from the mode.
   string    m_mode = "RUN";
   int       m_wait = 0;
   bit       m_step = 0;
   bit [2:0] m_cause = 0;
   bit       m_hack = 0, m_rack = 0, m_to = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = "RUN"; m_wait = 0; m_step = 0; m_cause = 0;
         m_hack = 0; m_rack = 0; m_to = 0;
      end else begin
         m_hack = 0; m_rack = 0; m_to = 0;
         if (m_mode == "RUN") begin
            if (core_dbg_mode) begin
               m_mode = "HALT"; m_hack = 1; m_cause = core_dcause; m_step = 0;
            end else if (halt_req_i) begin
               m_mode = "HREQ"; m_wait = 0;
            end
         end else if (m_mode == "HREQ") begin
            if (core_dbg_mode) begin
               m_mode = "HALT"; m_hack = 1; m_cause = core_dcause; m_step = 0;
            end else if (m_wait == TO) begin
               m_mode = "RUN"; m_to = 1;
            end else m_wait++;
         end else if (m_mode == "HALT") begin
            if (!core_dbg_mode) begin
               m_mode = "RUN"; m_rack = 1;
            end else if (resume_req_i) begin
               m_mode = "RES"; m_step = step_i; m_wait = 0;
            end
         end else begin
            if (!core_dbg_mode) begin
               m_mode = "RUN"; m_rack = 1;
            end else if (m_wait == TO) begin
               m_mode = "HALT"; m_to = 1; m_step = 0;
            end else m_wait++;
         end
      end
   end

   function automatic logic [10:0] exp_vec();
      bit hreq, res;
      hreq = (m_mode == "HREQ");
      res  = (m_mode == "RES");
      return {hreq, res, m_step, (m_mode == "HALT"), (hreq | res),
              m_hack, m_rack, m_to, m_cause};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      halt_req_i = 0; resume_req_i = 0; step_i = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 0; idle_inputs(); core_dbg_mode = 0; core_dcause = 0;
      step(); step();
      n_tests++;
      if ({dbg_irq_o, resume_flag_o, step_flag_o, halted_o, busy_o, halt_ack_o,
           resume_ack_o, timeout_o, halt_cause_o} !== 11'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %b required 0", {dbg_irq_o,
            resume_flag_o, step_flag_o, halted_o, busy_o, halt_ack_o, resume_ack_o,
            timeout_o, halt_cause_o});
      end
      rst_n = 1;
      step();
      n_tests++;
      if (halted_o !== 0 || busy_o !== 0) begin
         n_fail++; $display("FAIL reset_idle: halted %b busy %b required 0 0", halted_o, busy_o);
      end
   endtask

   task automatic test_halt();
      int irq_cycles = 0;
      halt_req_i = 1; step(); halt_req_i = 0;
      n_tests++;
      if (busy_o !== 1) begin n_fail++; $display("FAIL halt_busy: got %b required 1", busy_o); end
      repeat (2) begin if (dbg_irq_o) irq_cycles++; step(); end
      if (dbg_irq_o) irq_cycles++;
      core_dbg_mode = 1; core_dcause = 3;
      step();
      n_tests++;
      if (irq_cycles !== 3) begin n_fail++; $display("FAIL halt_irq_len: got %0d required 3", irq_cycles); end
      n_tests++;
      if ({halt_ack_o, halted_o, dbg_irq_o, busy_o} !== 4'b1100) begin
         n_fail++; $display("FAIL halt_entry: ack/halted/irq/busy got %b required 1100",
            {halt_ack_o, halted_o, dbg_irq_o, busy_o});
      end
      n_tests++;
      if (halt_cause_o !== 3'd3) begin n_fail++; $display("FAIL halt_cause: got %0d required 3", halt_cause_o); end
      step();
      n_tests++;
      if (halt_ack_o !== 0) begin n_fail++; $display("FAIL halt_ack_pulse: got %b required 0", halt_ack_o); end
   endtask

   task automatic test_resume();
      int rf_cycles = 0;
      resume_req_i = 1; step_i = 0; step(); idle_inputs();
      repeat (2) begin if (resume_flag_o) rf_cycles++; if (halted_o) rf_cycles += 100; step(); end
      // core dropped debug mode two cycles after the request
      core_dbg_mode = 0;
      step();
      // undo the extra sampling edge: the drop was driven after the 2nd cycle
      n_tests++;
      if (rf_cycles !== 2) begin n_fail++; $display("FAIL resume_flag_len: got %0d required 2", rf_cycles); end
      n_tests++;
      if ({resume_flag_o, resume_ack_o, halted_o, step_flag_o, busy_o} !== 5'b01000) begin
         n_fail++; $display("FAIL resume_exit: flag/ack/halted/step/busy got %b required 01000",
            {resume_flag_o, resume_ack_o, halted_o, step_flag_o, busy_o});
      end
      step();
      n_tests++;
      if (resume_ack_o !== 0) begin n_fail++; $display("FAIL resume_ack_pulse: got %b required 0", resume_ack_o); end
   endtask

   task automatic test_step();
      int sf_cycles = 0;
      core_dbg_mode = 1; core_dcause = 1; step();
      resume_req_i = 1; step_i = 1; step(); idle_inputs();
      core_dbg_mode = 0; step();
      n_tests++;
      if ({resume_ack_o, step_flag_o, halted_o} !== 3'b110) begin
         n_fail++; $display("FAIL step_leave: ack/step/halted got %b required 110",
            {resume_ack_o, step_flag_o, halted_o});
      end
      repeat (4) begin if (step_flag_o) sf_cycles++; step(); end
      core_dbg_mode = 1; core_dcause = 4;
      n_tests++;
      if (sf_cycles !== 4) begin n_fail++; $display("FAIL step_hold: got %0d required 4", sf_cycles); end
      step();
      n_tests++;
      if ({halt_ack_o, halted_o, step_flag_o, halt_cause_o} !== 6'b110100) begin
         n_fail++; $display("FAIL step_reentry: ack/halted/step/cause got %b required 110100",
            {halt_ack_o, halted_o, step_flag_o, halt_cause_o});
      end
   endtask

   task automatic test_halt_timeout();
      int irq_n = 0, to_n = 0, ack_n = 0;
      core_dbg_mode = 0; step(); step();
      halt_req_i = 1; step(); halt_req_i = 0;
      for (int i = 0; i < 40; i++) begin
         if (dbg_irq_o) irq_n++;
         if (timeout_o) to_n++;
         if (halt_ack_o) ack_n++;
         step();
      end
      n_tests++;
      if (irq_n !== TO + 1) begin n_fail++; $display("FAIL halt_to_irq_len: got %0d required %0d", irq_n, TO + 1); end
      n_tests++;
      if (to_n !== 1 || ack_n !== 0) begin
         n_fail++; $display("FAIL halt_to_pulses: timeouts %0d acks %0d required 1 0", to_n, ack_n);
      end
      n_tests++;
      if ({halted_o, busy_o, dbg_irq_o} !== 3'b000) begin
         n_fail++; $display("FAIL halt_to_state: got %b required 000", {halted_o, busy_o, dbg_irq_o});
      end
   endtask

   task automatic test_resume_timeout();
      int rf_n = 0, to_n = 0, ack_n = 0;
      core_dbg_mode = 1; core_dcause = 2; step(); step();
      resume_req_i = 1; step_i = 1; step(); idle_inputs();
      for (int i = 0; i < 40; i++) begin
         if (resume_flag_o) rf_n++;
         if (timeout_o) to_n++;
         if (halt_ack_o) ack_n++;
         step();
      end
      n_tests++;
      if (rf_n !== TO + 1) begin n_fail++; $display("FAIL res_to_flag_len: got %0d required %0d", rf_n, TO + 1); end
      n_tests++;
      if (to_n !== 1 || ack_n !== 0) begin
         n_fail++; $display("FAIL res_to_pulses: timeouts %0d acks %0d required 1 0", to_n, ack_n);
      end
      n_tests++;
      if ({halted_o, step_flag_o, halt_cause_o} !== 5'b10010) begin
         n_fail++; $display("FAIL res_to_state: halted/step/cause got %b required 10010",
            {halted_o, step_flag_o, halt_cause_o});
      end
      // Core answers a new halt on the very cycle the timeout would fire.
      core_dbg_mode = 0; step();
      halt_req_i = 1; step(); halt_req_i = 0;
      repeat (TO) step();
      n_tests++;
      if (dbg_irq_o !== 1) begin n_fail++; $display("FAIL edge_irq_still: got %b required 1", dbg_irq_o); end
      core_dbg_mode = 1; core_dcause = 5;
      step();
      n_tests++;
      if ({halt_ack_o, timeout_o, halted_o, halt_cause_o} !== 6'b101101) begin
         n_fail++; $display("FAIL edge_exit_wins: ack/to/halted/cause got %b required 101101",
            {halt_ack_o, timeout_o, halted_o, halt_cause_o});
      end
   endtask

   task automatic test_reset_mid();
      core_dbg_mode = 0; step();
      halt_req_i = 1; step(); halt_req_i = 0; step();
      n_tests++;
      if (busy_o !== 1) begin n_fail++; $display("FAIL mid_busy: got %b required 1", busy_o); end
      #2 rst_n = 0;
      #1;
      n_tests++;
      if ({dbg_irq_o, resume_flag_o, step_flag_o, halted_o, busy_o, halt_ack_o,
           resume_ack_o, timeout_o, halt_cause_o} !== 11'd0) begin
         n_fail++; $display("FAIL mid_reset_async: got %b required 0", {dbg_irq_o,
            resume_flag_o, step_flag_o, halted_o, busy_o, halt_ack_o, resume_ack_o,
            timeout_o, halt_cause_o});
      end
      core_dbg_mode = 1; core_dcause = 6;
      step(); step();
      rst_n = 1;
      step();
      n_tests++;
      if ({halt_ack_o, halted_o, halt_cause_o} !== 5'b11110) begin
         n_fail++; $display("FAIL mid_reset_capture: ack/halted/cause got %b required 11110",
            {halt_ack_o, halted_o, halt_cause_o});
      end
   endtask

   task automatic test_random();
      logic [10:0] got, want;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         halt_req_i   = ($urandom_range(0, 6) == 0);
         resume_req_i = ($urandom_range(0, 5) == 0);
         step_i       = 1'($urandom_range(0, 1));
         core_dcause  = 3'($urandom_range(0, 7));
         if (m_mode == "HREQ" && $urandom_range(0, 7) == 0) core_dbg_mode = 1;
         else if (m_mode == "RES" && $urandom_range(0, 7) == 0) core_dbg_mode = 0;
         else if ($urandom_range(0, 40) == 0) core_dbg_mode = ~core_dbg_mode;
         if ($urandom_range(0, 400) == 0) begin
            rst_n = 0; step(); rst_n = 1;
         end
         step();
         got  = {dbg_irq_o, resume_flag_o, step_flag_o, halted_o, busy_o,
                 halt_ack_o, resume_ack_o, timeout_o, halt_cause_o};
         want = exp_vec();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL random_cycle %0d: got %b required %b (mode %s)", cyc, got, want, m_mode);
         end
      end
      idle_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_halt();
      test_resume();
      test_step();
      test_halt_timeout();
      test_resume_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
